hc_stream_map_engine: RTL

Multi-line streaming successor to the single-line HardCloud sample engine. It reads `num_lines` cache lines from a source buffer over CCI-P c0 and keeps several reads outstanding. Each line is transformed with a per-lane add, written to the matching line of a destination buffer over c1, and completion is signalled with a DSM write. It sits between the AFU CSR block, which supplies addresses, length and start/stop, and the registered CCI-P Rx/Tx structs at the top level.

---
 rtl/hc_stream_pkg.sv | 42 ++++
 rtl/hc_sync_fifo.sv | 54 +++++
 rtl/hc_stream_map_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hc_stream_pkg.sv
// hc_stream_pkg
//   Shared types and constants for the streaming map engine and the AFU CSR
//   block: engine state encoding, write-buffer entry layout, CSR offsets and
//   control-register command codes.
package hc_stream_pkg;

   localparam int CL_ADDR_W = 42;
   localparam int CL_DATA_W = 512;
   localparam int MDATA_W   = 16;

   // CSR byte offsets decoded by the CSR block
   localparam logic [15:0] CSR_DSM_ADDR  = 16'h0A00;
   localparam logic [15:0] CSR_CONTROL   = 16'h0A08;
   localparam logic [15:0] CSR_SRC_ADDR  = 16'h0A10;
   localparam logic [15:0] CSR_DST_ADDR  = 16'h0A18;
   localparam logic [15:0] CSR_NUM_LINES = 16'h0A20;

   // Commands written to CSR_CONTROL
   localparam logic [31:0] HC_CONTROL_START = 32'd3;
   localparam logic [31:0] HC_CONTROL_STOP  = 32'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_FINISH = 3'd3,
      ST_DONE   = 3'd4
   } t_hc_stream_state;

   // One buffered c1 write: destination line address plus transformed data
   typedef struct packed {
      logic [CL_ADDR_W-1:0] addr;
      logic [CL_DATA_W-1:0] data;
   } t_wbuf_entry;

   // Cache-line address of line idx relative to base, modulo 2^42
   function automatic logic [CL_ADDR_W-1:0] cl_offset(input logic [CL_ADDR_W-1:0] base,
                                                      input logic [31:0]          idx);
      return base + CL_ADDR_W'(idx);
   endfunction

endpackage

// File: rtl/hc_sync_fifo.sv
// hc_sync_fifo
//   Synchronous first-word-fall-through FIFO: dout shows the head entry
//   whenever empty is low, pop advances it.
//   Ports: clk, reset (sync, active-high), push/din write side,
//   pop/dout read side, count (occupancy 0..DEPTH), full, empty.
//   Push while full and pop while empty are ignored.
module hc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   input  logic                    pop,
   output logic [WIDTH-1:0]        dout,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/hc_stream_map_engine.sv
// hc_stream_map_engine
//   Streams num_lines cache lines from src over CCI-P c0, adds ADD_VALUE to
//   every LANE_W-bit lane, writes each line to the same index under dst over
//   c1, then posts a completion word of 1 to dsm+1.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     start, stop                start pulse (IDLE only), stop level (DONE->IDLE)
//     src/dst/dsm_addr, num_lines job description, sampled on start
//     c0_alm_full, c1_alm_full   Tx almost-full, gate request registration
//     rd_valid/rd_addr/rd_mdata  c0 RDLINE request (mdata = low 16 bits of index)
//     rsp_valid/mdata/data       c0 RDLINE response, any order
//     wr_valid/wr_addr/wr_data   c1 single-beat write
//     wr_rsp_valid               c1 write response
//     busy, done, lines_done     status (lines_done = acknowledged writes)
module hc_stream_map_engine
   import hc_stream_pkg::*;
#(
   parameter int              LANE_W    = 32,
   parameter longint unsigned ADD_VALUE = 10,
   parameter int              DEPTH     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [CL_ADDR_W-1:0]  src_addr,
   input  logic [CL_ADDR_W-1:0]  dst_addr,
   input  logic [CL_ADDR_W-1:0]  dsm_addr,
   input  logic [31:0]           num_lines,
   input  logic                  c0_alm_full,
   input  logic                  c1_alm_full,
   output logic                  rd_valid,
   output logic [CL_ADDR_W-1:0]  rd_addr,
   output logic [MDATA_W-1:0]    rd_mdata,
   input  logic                  rsp_valid,
   input  logic [MDATA_W-1:0]    rsp_mdata,
   input  logic [CL_DATA_W-1:0]  rsp_data,
   output logic                  wr_valid,
   output logic [CL_ADDR_W-1:0]  wr_addr,
   output logic [CL_DATA_W-1:0]  wr_data,
   input  logic                  wr_rsp_valid,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           lines_done
);
   localparam int NUM_LANES = CL_DATA_W / LANE_W;
   localparam int CW        = $clog2(DEPTH) + 1;
   localparam logic [LANE_W-1:0] ADD_L = LANE_W'(ADD_VALUE);

   t_hc_stream_state state, state_n;

   logic [CL_ADDR_W-1:0] src_q, dst_q, dsm_q;
   logic [31:0]          num_q;
   logic [31:0]          issued;
   logic [31:0]          written;
   logic [31:0]          acked;
   logic [CW-1:0]        rd_out;     // reads issued, response not yet seen
   logic [CW-1:0]        credits;

   logic                 launch, rd_issue, wr_pop, dsm_send, rsp_acc, ack_inc;

   t_wbuf_entry          fifo_din, fifo_dout;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_full, fifo_empty;

   logic [MDATA_W-1:0]   rsp_dist;
   logic [31:0]          rsp_idx;
   logic [CL_DATA_W-1:0] rsp_xform;

   //--------------------------------------------------------------------------
   // Response path. The outstanding window never exceeds DEPTH <= 2^15, so the
   // 16-bit distance back from the issue counter recovers the full index.
   //--------------------------------------------------------------------------
   assign rsp_dist = issued[MDATA_W-1:0] - rsp_mdata;
   assign rsp_idx  = issued - {16'd0, rsp_dist};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign rsp_xform[LANE_W*i +: LANE_W] = rsp_data[LANE_W*i +: LANE_W] + ADD_L;
   end

   assign fifo_din.addr = cl_offset(dst_q, rsp_idx);
   assign fifo_din.data = rsp_xform;

   // Credits cover both in-flight reads and buffered lines, so the buffer
   // always has room for every response that can still arrive.
   assign credits = rd_out + fifo_count;

   hc_sync_fifo #(
      .WIDTH ($bits(t_wbuf_entry)),
      .DEPTH (DEPTH)
   ) u_wbuf (
      .clk   (clk),
      .reset (reset),
      .push  (rsp_acc),
      .din   (fifo_din),
      .pop   (wr_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   //--------------------------------------------------------------------------
   // FSM: state register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   //--------------------------------------------------------------------------
   // FSM: next state
   //--------------------------------------------------------------------------
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:   if (start) state_n = (num_lines == '0) ? ST_FINISH : ST_RUN;
         ST_RUN:    if (written == num_q) state_n = ST_DRAIN;
         ST_DRAIN:  if (acked == num_q) state_n = ST_FINISH;
         ST_FINISH: if (!c1_alm_full) state_n = ST_DONE;
         ST_DONE:   if (stop) state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   //--------------------------------------------------------------------------
   // FSM: per-cycle action strobes
   //--------------------------------------------------------------------------
   always_comb begin
      launch   = 1'b0;
      rd_issue = 1'b0;
      wr_pop   = 1'b0;
      dsm_send = 1'b0;
      rsp_acc  = 1'b0;
      ack_inc  = 1'b0;
      unique case (state)
         ST_IDLE: launch = start;
         ST_RUN: begin
            rd_issue = (issued < num_q) && !c0_alm_full && (credits < CW'(DEPTH));
            wr_pop   = !fifo_empty && !c1_alm_full;
            // rd_out guard drops anything that cannot belong to this job
            rsp_acc  = rsp_valid && (rd_out != '0) && !fifo_full;
            ack_inc  = wr_rsp_valid && (acked < num_q);
         end
         ST_DRAIN:  ack_inc  = wr_rsp_valid && (acked < num_q);
         ST_FINISH: dsm_send = !c1_alm_full;
         default: ;
      endcase
   end

   //--------------------------------------------------------------------------
   // Datapath and registered outputs
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_mdata <= '0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         dsm_q    <= '0;
         num_q    <= '0;
         issued   <= '0;
         written  <= '0;
         acked    <= '0;
         rd_out   <= '0;
      end else begin
         busy <= (state_n == ST_RUN) || (state_n == ST_DRAIN) || (state_n == ST_FINISH);
         done <= (state_n == ST_DONE);

         rd_valid <= rd_issue;
         if (rd_issue) begin
            rd_addr  <= cl_offset(src_q, issued);
            rd_mdata <= issued[MDATA_W-1:0];
            issued   <= issued + 32'd1;
         end

         wr_valid <= wr_pop || dsm_send;
         if (wr_pop) begin
            wr_addr <= fifo_dout.addr;
            wr_data <= fifo_dout.data;
            written <= written + 32'd1;
         end else if (dsm_send) begin
            wr_addr <= dsm_q + CL_ADDR_W'(1);
            wr_data <= CL_DATA_W'(1);
         end

         rd_out <= rd_out + CW'(rd_issue) - CW'(rsp_acc);
         if (ack_inc) acked <= acked + 32'd1;

         if (launch) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            dsm_q   <= dsm_addr;
            num_q   <= num_lines;
            issued  <= '0;
            written <= '0;
            acked   <= '0;
         end
      end
   end

   assign lines_done = acked;

endmodule
